// File: rtl/rsa_modexp.sv
// Purpose: computes Result = Data^Key mod N by repeated multiply/reduce, one run per reset release.
// Latency: Done rises on edge 1 + 2*Key after release (edge 1 when Key == 0 or N == 0).
// Backpressure: none; operands are sampled once in LOAD and Result/Done then hold until reset.
module rsa_modexp #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Data,
    input  logic [WIDTH-1:0] Key,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] Result,
    output logic             Done
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MUL  = 2'd1,
        MOD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   base_q, base_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    // Divisors are forced non-zero so the remainder operators never see a zero divisor;
    // the N == 0 case is resolved in LOAD and never reaches the reduction path.
    logic [WIDTH-1:0]   n_in_safe;
    logic [WIDTH-1:0]   n_q_safe;
    logic [WIDTH-1:0]   mod_r;

    assign n_in_safe = (N == ZERO) ? ONE : N;
    assign n_q_safe  = (n_q == ZERO) ? ONE : n_q;
    assign mod_r     = WIDTH'(prod_q % {{WIDTH{1'b0}}, n_q_safe});

    // Next-state and datapath updates for the LOAD / MUL / MOD / DONE sequence.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        prod_d   = prod_q;
        count_d  = count_q;
        n_d      = n_q;
        result_d = result_q;
        done_d   = done_q;

        case (state_q)
            LOAD: begin
                // Operands are captured here only; later input changes are ignored.
                n_d     = N;
                base_d  = (N == ZERO) ? ZERO : (Data % n_in_safe);
                count_d = Key;
                acc_d   = (N > ONE) ? ONE : ZERO;
                if (N == ZERO) begin
                    result_d = ZERO;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (Key == ZERO) begin
                    result_d = (N > ONE) ? ONE : ZERO;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d  = MUL;
                end
            end
            MUL: begin
                // Full double-width product so nothing is lost before reduction.
                prod_d  = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, base_q};
                state_d = MOD;
            end
            MOD: begin
                acc_d   = mod_r;
                count_d = count_q - ONE;
                if (count_q == ONE) begin
                    result_d = mod_r;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    state_d  = MUL;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOAD;
            acc_q    <= '0;
            base_q   <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            n_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
            n_q      <= n_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign Result = result_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Purpose: self-checking bench for rsa_modexp against a plain-arithmetic modexp reference.
// Latency: checks Done edge number, Result value and quiet outputs before Done for each run.
// Backpressure: none; each run is started by a reset pulse and bounded by an edge budget.
module tb_rsa_modexp;

    localparam int W = 6;
    localparam int EDGE_BUDGET = 200;

    logic         clk;
    logic         reset;
    logic [W-1:0] Data;
    logic [W-1:0] Key;
    logic [W-1:0] N;
    logic [W-1:0] Result;
    logic         Done;

    int checks;
    int failures;

    rsa_modexp #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .Data   (Data),
        .Key    (Key),
        .N      (N),
        .Result (Result),
        .Done   (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: square-free repeated multiplication using ordinary integer arithmetic.
    function automatic logic [W-1:0] ref_modexp(input int d, input int k, input int n);
        longint r;
        longint b;
        if (n == 0) return '0;
        r = 1 % n;
        b = d % n;
        for (int i = 0; i < k; i++) r = (r * b) % n;
        return W'(r);
    endfunction

    function automatic int ref_latency(input int k, input int n);
        if (n == 0 || k == 0) return 1;
        return 1 + 2 * k;
    endfunction

    // Pulse reset for one cycle with the given operands; release lands on a falling edge.
    task automatic start_run(input logic [W-1:0] d, input logic [W-1:0] k, input logic [W-1:0] n);
        @(negedge clk);
        reset = 1'b0;
        Data  = d;
        Key   = k;
        N     = n;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Count edges after release until Done, checking edge, result and quiet outputs before it.
    task automatic run_case(input string name, input logic [W-1:0] d, input logic [W-1:0] k,
                            input logic [W-1:0] n);
        logic [W-1:0] exp_r;
        int exp_edge;
        int got_edge;
        int early_bad;
        exp_r     = ref_modexp(int'(d), int'(k), int'(n));
        exp_edge  = ref_latency(int'(k), int'(n));
        got_edge  = -1;
        early_bad = 0;
        start_run(d, k, n);
        for (int e = 1; e <= EDGE_BUDGET && got_edge < 0; e++) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1) got_edge = e;
            else if (Result !== '0 || Done !== 1'b0) early_bad++;
        end
        checks++;
        if (got_edge != exp_edge) begin
            failures++;
            $display("FAIL %s done_edge: got %0d expected %0d (D=%0d K=%0d N=%0d)",
                     name, got_edge, exp_edge, d, k, n);
        end
        checks++;
        if (Result !== exp_r) begin
            failures++;
            $display("FAIL %s result: got %0d expected %0d (D=%0d K=%0d N=%0d)",
                     name, Result, exp_r, d, k, n);
        end
        checks++;
        if (early_bad != 0) begin
            failures++;
            $display("FAIL %s quiet_before_done: %0d edges with nonzero Result/Done, expected 0",
                     name, early_bad);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        Data  = 6'd5;
        Key   = 6'd3;
        N     = 6'd33;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Result !== '0) begin
            failures++;
            $display("FAIL reset_result: got %0d expected 0", Result);
        end
        checks++;
        if (Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %0b expected 0", Done);
        end
    endtask

    task automatic test_plan_vectors();
        run_case("n28_zero_result", 6'd28, 6'd60, 6'd28);
        run_case("n33_d4_k3", 6'd4, 6'd3, 6'd33);
        run_case("n55_d2_k7", 6'd2, 6'd7, 6'd55);
        run_case("key0_n33", 6'd5, 6'd0, 6'd33);
        run_case("key0_n1", 6'd5, 6'd0, 6'd1);
        run_case("n0", 6'd9, 6'd4, 6'd0);
        run_case("data_ge_n", 6'd40, 6'd2, 6'd33);
        run_case("n1_nonzero_key", 6'd7, 6'd5, 6'd1);
        run_case("max_key", 6'd3, 6'd63, 6'd61);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_case("random", W'($urandom_range(0, 63)), W'($urandom_range(0, 20)),
                     W'($urandom_range(0, 63)));
        end
    endtask

    // Reset mid-run must clear immediately and restart with the new operands.
    task automatic test_mid_reset();
        start_run(6'd5, 6'd60, 6'd61);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (Result !== '0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_clear: got Result=%0d Done=%0b expected 0/0", Result, Done);
        end
        run_case("after_mid_reset", 6'd2, 6'd7, 6'd55);
    endtask

    // After Done, input changes are ignored; an async reset clears without a clock edge.
    task automatic test_hold_and_async_clear();
        int bad;
        run_case("hold_setup", 6'd4, 6'd3, 6'd33);
        @(negedge clk);
        Data = 6'd5;
        Key  = 6'd9;
        N    = 6'd50;
        bad  = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (Result !== 6'd31 || Done !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_after_done: %0d edges deviated from Result=31 Done=1, last Result=%0d Done=%0b",
                     bad, Result, Done);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (Result !== '0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL async_clear_after_done: got Result=%0d Done=%0b expected 0/0", Result, Done);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Data     = '0;
        Key      = '0;
        N        = '0;
        reset    = 1'b1;
        #2;
        reset    = 1'b0;
        test_reset();
        test_plan_vectors();
        test_mid_reset();
        test_hold_and_async_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
